// File: rtl/parking_pkg.sv
// parking_pkg: lane state encoding, default lane timing and event widths
// shared by the parking front-end and the occupancy counter.
package parking_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_ID, OPEN, PASSING, HOLD} lane_state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_ID_TIMEOUT = 64;
  localparam int DEF_PASS_TIMEOUT = 256;
  localparam int EVENT_W = 1;
  localparam int CLASS_W = 1;
endpackage

// File: rtl/parking_lane_fsm.sv
// parking_lane_fsm: sensor conditioning, in-state timer and barrier
// sequencing for one lane; IS_ENTRY adds the space check and denial pulse.
module parking_lane_fsm
  import parking_pkg::*;
#(
  parameter bit IS_ENTRY = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ID_TIMEOUT = DEF_ID_TIMEOUT,
  parameter int PASS_TIMEOUT = DEF_PASS_TIMEOUT
) (
  input  logic clk,
  input  logic start,
  input  logic arrive,
  input  logic pass,
  input  logic id_valid,
  input  logic id_uni,
  input  logic space,
  input  logic uni_space,
  output logic barrier_up,
  output logic denied,
  output logic done,
  output logic uni
);
  localparam int MAX_T = (ID_TIMEOUT > PASS_TIMEOUT) ? ID_TIMEOUT : PASS_TIMEOUT;
  localparam int TW = $clog2(MAX_T) + 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  lane_state_t state, state_n;
  logic [1:0] raw, s1, s2, deb;
  logic [1:0][CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic grant, accept;
  assign raw = {pass, arrive};
  assign grant = !IS_ENTRY || (id_uni ? uni_space : space);
  assign accept = state == WAIT_ID && id_valid;
  assign done = state == PASSING && !deb[1] && !deb[0];
  assign barrier_up = state == OPEN || state == PASSING;
  // bit 0 is the arrive loop, bit 1 the pass loop
  always_ff @(posedge clk or negedge start)
    if (!start) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++)
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          deb[i] <= s2[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (deb[0]) state_n = WAIT_ID;
      WAIT_ID: if (id_valid) state_n = grant ? OPEN : HOLD;
               else if (timer >= TW'(ID_TIMEOUT)) state_n = HOLD;
      OPEN:    if (deb[1]) state_n = PASSING;
               else if (timer >= TW'(PASS_TIMEOUT)) state_n = HOLD;
      PASSING: if (done) state_n = IDLE;
      HOLD:    if (!deb[0]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge start)
    if (!start) begin
      state <= IDLE;
      timer <= '0;
      denied <= 1'b0;
      uni <= 1'b0;
    end else begin
      state <= state_n;
      timer <= (state_n != state) ? '0 : (timer == TW'(MAX_T)) ? timer : timer + 1'b1;
      denied <= IS_ENTRY && accept && !grant;
      uni <= accept ? id_uni : uni;
    end
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit lanes plus registered car events; an exit
// completing together with an entry is deferred one cycle via a pending flag.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ID_TIMEOUT = DEF_ID_TIMEOUT,
  parameter int PASS_TIMEOUT = DEF_PASS_TIMEOUT
) (
  input  logic clk,
  input  logic start,
  input  logic ent_arrive,
  input  logic ext_arrive,
  input  logic ent_pass,
  input  logic ext_pass,
  input  logic ent_id_valid,
  input  logic ext_id_valid,
  input  logic ent_id_uni,
  input  logic ext_id_uni,
  input  logic is_vacated_space,
  input  logic uni_is_vacated_space,
  output logic ent_barrier_up,
  output logic ext_barrier_up,
  output logic ent_denied,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited
);
  logic ent_done, ext_done, ent_uni, ext_uni, ent_den, ext_den;
  logic pending, pending_uni, ext_fire;
  parking_lane_fsm #(
    .IS_ENTRY(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ID_TIMEOUT(ID_TIMEOUT), .PASS_TIMEOUT(PASS_TIMEOUT)
  ) u_ent (
    .clk(clk), .start(start), .arrive(ent_arrive), .pass(ent_pass),
    .id_valid(ent_id_valid), .id_uni(ent_id_uni),
    .space(is_vacated_space), .uni_space(uni_is_vacated_space),
    .barrier_up(ent_barrier_up), .denied(ent_den), .done(ent_done), .uni(ent_uni)
  );
  parking_lane_fsm #(
    .IS_ENTRY(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ID_TIMEOUT(ID_TIMEOUT), .PASS_TIMEOUT(PASS_TIMEOUT)
  ) u_ext (
    .clk(clk), .start(start), .arrive(ext_arrive), .pass(ext_pass),
    .id_valid(ext_id_valid), .id_uni(ext_id_uni),
    .space(1'b1), .uni_space(1'b1),
    .barrier_up(ext_barrier_up), .denied(ext_den), .done(ext_done), .uni(ext_uni)
  );
  // the exit lane never denies, so its flag is constant 0
  assign ent_denied = ent_den | ext_den;
  assign ext_fire = pending | (ext_done & ~ent_done);
  always_ff @(posedge clk or negedge start)
    if (!start) begin
      car_entered <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited <= 1'b0;
      is_uni_car_exited <= 1'b0;
      pending <= 1'b0;
      pending_uni <= 1'b0;
    end else begin
      car_entered <= ent_done;
      is_uni_car_entered <= ent_done ? ent_uni : is_uni_car_entered;
      car_exited <= ext_fire;
      is_uni_car_exited <= ext_fire ? (pending ? pending_uni : ext_uni) : is_uni_car_exited;
      pending <= ent_done & ext_done;
      pending_uni <= (ent_done & ext_done) ? ext_uni : pending_uni;
    end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed scenarios plus randomized traffic on both
// lanes, checked every cycle against a behavioural model of the lane rules.
module tb_parking_gate_ctrl;
  import parking_pkg::*;
  localparam int D = 4, ID_T = 64, PASS_T = 256, MAX_T = 256;
  localparam int P_IDLE = 0, P_WAIT = 1, P_OPEN = 2, P_PASS = 3, P_HOLD = 4;
  logic clk = 0, start = 0;
  logic ent_arrive = 0, ext_arrive = 0, ent_pass = 0, ext_pass = 0;
  logic ent_id_valid = 0, ext_id_valid = 0, ent_id_uni = 0, ext_id_uni = 0;
  logic is_vacated_space = 1, uni_is_vacated_space = 1;
  logic ent_barrier_up, ext_barrier_up, ent_denied;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  int checks = 0, errors = 0, cyc = 0;
  int n_ent = 0, n_ext = 0, n_den = 0, n_bar = 0, ent_cyc = 0, ext_cyc = 0;
  bit ent_uni_seen, ext_uni_seen;
  // behavioural model: [lane][0 = arrive, 1 = pass]
  int ph [2], tm [2], seen [2][2];
  bit cls [2], s1 [2][2], s2 [2][2], db [2][2];
  logic [D-1:0] hv [2][2];
  bit exq [$];
  bit m_ent, m_ent_uni, m_ext, m_ext_uni, m_den;

  parking_gate_ctrl dut (
    .clk(clk), .start(start),
    .ent_arrive(ent_arrive), .ext_arrive(ext_arrive),
    .ent_pass(ent_pass), .ext_pass(ext_pass),
    .ent_id_valid(ent_id_valid), .ext_id_valid(ext_id_valid),
    .ent_id_uni(ent_id_uni), .ext_id_uni(ext_id_uni),
    .is_vacated_space(is_vacated_space), .uni_is_vacated_space(uni_is_vacated_space),
    .ent_barrier_up(ent_barrier_up), .ext_barrier_up(ext_barrier_up),
    .ent_denied(ent_denied), .car_entered(car_entered),
    .is_uni_car_entered(is_uni_car_entered), .car_exited(car_exited),
    .is_uni_car_exited(is_uni_car_exited)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      ph[l] = P_IDLE; tm[l] = 0; cls[l] = 0;
      for (int k = 0; k < 2; k++) begin
        s1[l][k] = 0; s2[l][k] = 0; db[l][k] = 0; hv[l][k] = '0; seen[l][k] = 0;
      end
    end
    exq.delete();
    m_ent = 0; m_ent_uni = 0; m_ext = 0; m_ext_uni = 0; m_den = 0;
  endtask

  task automatic model_step();
    bit raw [2][2];
    bit idv [2], idu [2], dn [2];
    bit ok;
    int nx;
    raw[0][0] = ent_arrive; raw[0][1] = ent_pass; raw[1][0] = ext_arrive; raw[1][1] = ext_pass;
    idv[0] = ent_id_valid; idu[0] = ent_id_uni; idv[1] = ext_id_valid; idu[1] = ext_id_uni;
    m_den = 0;
    for (int l = 0; l < 2; l++) begin
      dn[l] = ph[l] == P_PASS && !db[l][0] && !db[l][1];
      nx = ph[l];
      case (ph[l])
        P_IDLE: if (db[l][0]) nx = P_WAIT;
        P_WAIT: if (idv[l]) begin
                  cls[l] = idu[l];
                  ok = (l == 1) || (idu[l] ? uni_is_vacated_space : is_vacated_space);
                  nx = ok ? P_OPEN : P_HOLD;
                  if (!ok) m_den = 1;
                end else if (tm[l] >= ID_T) nx = P_HOLD;
        P_OPEN: if (db[l][1]) nx = P_PASS; else if (tm[l] >= PASS_T) nx = P_HOLD;
        P_PASS: if (dn[l]) nx = P_IDLE;
        default: if (!db[l][0]) nx = P_IDLE;
      endcase
      tm[l] = (nx != ph[l]) ? 0 : (tm[l] < MAX_T ? tm[l] + 1 : tm[l]);
      ph[l] = nx;
      for (int k = 0; k < 2; k++) begin
        hv[l][k] = {hv[l][k][D-2:0], s2[l][k]};
        if (seen[l][k] < D) seen[l][k]++;
        if (seen[l][k] >= D && (hv[l][k] == '0 || hv[l][k] == '1) && hv[l][k][0] != db[l][k])
          db[l][k] = hv[l][k][0];
        s2[l][k] = s1[l][k];
        s1[l][k] = raw[l][k];
      end
    end
    m_ent = dn[0];
    if (dn[0]) m_ent_uni = cls[0];
    m_ext = 0;
    if (exq.size() > 0) begin m_ext = 1; m_ext_uni = exq.pop_front(); end
    if (dn[1]) begin
      if (dn[0] || m_ext) exq.push_back(cls[1]);
      else begin m_ext = 1; m_ext_uni = cls[1]; end
    end
  endtask

  always @(posedge clk or negedge start)
    if (!start) model_reset();
    else model_step();

  always @(negedge clk) begin
    chk("car_entered", car_entered, m_ent);
    chk("is_uni_car_entered", is_uni_car_entered, m_ent_uni);
    chk("car_exited", car_exited, m_ext);
    chk("is_uni_car_exited", is_uni_car_exited, m_ext_uni);
    chk("ent_denied", ent_denied, m_den);
    chk("ent_barrier_up", ent_barrier_up, ph[0] == P_OPEN || ph[0] == P_PASS);
    chk("ext_barrier_up", ext_barrier_up, ph[1] == P_OPEN || ph[1] == P_PASS);
    if (car_entered) begin n_ent++; ent_cyc = cyc; ent_uni_seen = is_uni_car_entered; end
    if (car_exited) begin n_ext++; ext_cyc = cyc; ext_uni_seen = is_uni_car_exited; end
    if (ent_denied) n_den++;
    if (ent_barrier_up) n_bar++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic set_arr(input int l, input bit a);
    if (l == 0) ent_arrive = a; else ext_arrive = a;
  endtask
  task automatic set_pass(input int l, input bit p);
    if (l == 0) ent_pass = p; else ext_pass = p;
  endtask
  task automatic set_id(input int l, input bit v, input bit u);
    if (l == 0) begin ent_id_valid = v; ent_id_uni = u; end
    else begin ext_id_valid = v; ext_id_uni = u; end
  endtask

  // mode 0: full pass, 1: no ID read, 2: car backs out after the grant
  task automatic car(input int l, input bit uni, input int mode, input int pre,
                     input int pw, input int phold, input int ad);
    set_arr(l, 1);
    repeat (pre) @(negedge clk);
    if (mode == 1) repeat (ID_T + 12) @(negedge clk);
    else begin
      set_id(l, 1, uni);
      @(negedge clk);
      set_id(l, 0, 1'($urandom));
    end
    if (mode == 2) begin
      repeat (PASS_T + 12) @(negedge clk);
      set_arr(l, 0);
    end else begin
      repeat (pw) @(negedge clk);
      set_pass(l, 1);
      repeat (phold) @(negedge clk);
      set_arr(l, 0);
      repeat (ad) @(negedge clk);
      set_pass(l, 0);
    end
    repeat (14) @(negedge clk);
  endtask

  task automatic rand_lane(input int l, input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(9) < 3) begin
        set_arr(l, 1); @(negedge clk); set_arr(l, 0); @(negedge clk);
      end
      r = $urandom_range(9);
      car(l, 1'($urandom), r == 0 ? 1 : r == 1 ? 2 : 0, $urandom_range(14, 8),
          $urandom_range(5, 1), $urandom_range(10, 6), $urandom_range(3, 0));
    end
  endtask

  initial begin
    int b0, e0, x0, d0, acc;
    bit done_rnd;
    repeat (3) @(negedge clk);
    chk("reset_car_entered", car_entered, 0);
    chk("reset_car_exited", car_exited, 0);
    chk("reset_ent_barrier", ent_barrier_up, 0);
    chk("reset_ent_state", 32'(dut.u_ent.state), 32'(IDLE));
    start = 1;
    repeat (3) @(negedge clk);

    // normal entry with exact arrive-to-WAIT_ID latency
    b0 = n_bar; e0 = n_ent;
    ent_arrive = 1;
    repeat (6) @(negedge clk);
    ent_id_valid = 1; ent_id_uni = 0;
    @(negedge clk);
    chk("early_id_ignored", ent_barrier_up, 0);
    @(negedge clk);
    ent_id_valid = 0;
    acc = cyc;
    chk("barrier_after_id", ent_barrier_up, 1);
    repeat (2) @(negedge clk);
    ent_pass = 1;
    repeat (8) @(negedge clk);
    ent_arrive = 0;
    repeat (2) @(negedge clk);
    ent_pass = 0;
    repeat (15) @(negedge clk);
    chk("normal_entry_pulses", n_ent - e0, 1);
    chk("normal_entry_uni", ent_uni_seen, 0);
    chk("normal_barrier_span", n_bar - b0, ent_cyc - acc);

    // uni car with no uni space
    b0 = n_bar; e0 = n_ent; d0 = n_den;
    uni_is_vacated_space = 0;
    ent_arrive = 1;
    repeat (8) @(negedge clk);
    ent_id_valid = 1; ent_id_uni = 1;
    @(negedge clk);
    ent_id_valid = 0; uni_is_vacated_space = 1;
    chk("denied_pulse", ent_denied, 1);
    @(negedge clk);
    chk("denied_one_cycle", ent_denied, 0);
    ent_pass = 1;
    repeat (6) @(negedge clk);
    ent_arrive = 0; ent_pass = 0;
    repeat (15) @(negedge clk);
    chk("denied_no_entry", n_ent - e0, 0);
    chk("denied_no_barrier", n_bar - b0, 0);
    chk("denied_count", n_den - d0, 1);
    chk("denied_back_idle", 32'(dut.u_ent.state), 32'(IDLE));

    // bouncing arrive, then a 6-cycle stable high and a pass timeout
    b0 = n_bar; e0 = n_ent;
    for (int i = 0; i < 10; i++) begin
      ent_arrive = ~ent_arrive;
      ent_id_valid = (i == 5);
      repeat (2) @(negedge clk);
    end
    ent_arrive = 0; ent_id_valid = 0;
    repeat (8) @(negedge clk);
    chk("bounce_no_barrier", n_bar - b0, 0);
    chk("bounce_idle", 32'(dut.u_ent.state), 32'(IDLE));
    ent_arrive = 1;
    repeat (6) @(negedge clk);
    ent_arrive = 0;
    repeat (3) @(negedge clk);
    ent_id_valid = 1; ent_id_uni = 0;
    @(negedge clk);
    ent_id_valid = 0;
    chk("stable6_granted", ent_barrier_up, 1);
    repeat (300) @(negedge clk);
    chk("pass_timeout_span", n_bar - b0, 257);
    chk("pass_timeout_no_event", n_ent - e0, 0);

    // ID timeout: a late ID must be ignored
    b0 = n_bar; d0 = n_den;
    ent_arrive = 1;
    repeat (80) @(negedge clk);
    ent_id_valid = 1;
    @(negedge clk);
    ent_id_valid = 0;
    repeat (3) @(negedge clk);
    ent_arrive = 0;
    repeat (12) @(negedge clk);
    chk("id_timeout_no_barrier", n_bar - b0, 0);
    chk("id_timeout_no_deny", n_den - d0, 0);
    chk("id_timeout_idle", 32'(dut.u_ent.state), 32'(IDLE));

    // simultaneous completion: entry normal, exit uni
    e0 = n_ent; x0 = n_ext;
    fork
      car(0, 0, 0, 9, 2, 8, 1);
      car(1, 1, 0, 9, 2, 8, 1);
    join
    chk("sim_entries", n_ent - e0, 1);
    chk("sim_exits", n_ext - x0, 1);
    chk("sim_exit_delay", ext_cyc - ent_cyc, 1);
    chk("sim_exit_uni", ext_uni_seen, 1);
    chk("sim_entry_uni", ent_uni_seen, 0);

    // randomized traffic on both lanes with random space availability
    done_rnd = 0;
    fork
      begin
        fork
          rand_lane(0, 25);
          rand_lane(1, 25);
        join
        done_rnd = 1;
      end
      while (!done_rnd) begin
        @(negedge clk);
        is_vacated_space = $urandom_range(3) != 0;
        uni_is_vacated_space = $urandom_range(3) != 0;
      end
    join
    is_vacated_space = 1; uni_is_vacated_space = 1;
    repeat (5) @(negedge clk);

    // reset while a car is in PASSING
    ent_arrive = 1;
    repeat (8) @(negedge clk);
    ent_id_valid = 1; ent_id_uni = 0;
    @(negedge clk);
    ent_id_valid = 0;
    repeat (2) @(negedge clk);
    ent_pass = 1;
    repeat (8) @(negedge clk);
    chk("pre_reset_passing", 32'(dut.u_ent.state), 32'(PASSING));
    chk("pre_reset_barrier", ent_barrier_up, 1);
    #2 start = 0;
    #1;
    chk("rst_ent_barrier", ent_barrier_up, 0);
    chk("rst_ext_barrier", ext_barrier_up, 0);
    chk("rst_car_entered", car_entered, 0);
    chk("rst_car_exited", car_exited, 0);
    chk("rst_denied", ent_denied, 0);
    ent_arrive = 0; ent_pass = 0;
    repeat (2) @(negedge clk);
    e0 = n_ent;
    start = 1;
    repeat (20) @(negedge clk);
    chk("post_reset_no_event", n_ent - e0, 0);
    chk("post_reset_idle", 32'(dut.u_ent.state), 32'(IDLE));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Upstream front-end of the parking controller. Conditions the raw entry/exit lane sensors and ID-reader inputs, sequences each barrier, and emits the single-cycle `car_entered` / `car_exited` events with their university-car class flags. Those events feed the occupancy counter directly. The entry lane is gated by the counter's `is_vacated_space` and `uni_is_vacated_space` outputs, so a car is admitted only when a space of its class exists.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive equal synchronized samples required before a sensor level is accepted.
- `ID_TIMEOUT`, default 64: cycles allowed in WAIT_ID before the lane gives up.
- `PASS_TIMEOUT`, default 256: cycles allowed in OPEN for the pass sensor to trip.
- `clk`  in  1: single clock; all state on rising edge.
- `start`  in  1: asynchronous, active-low reset; 0 holds the block in reset, 1 runs.
- `ent_arrive`, `ext_arrive`  in  1 each: raw loop sensors in front of the entry/exit barrier.
- `ent_pass`, `ext_pass`  in  1 each: raw loop sensors behind the entry/exit barrier.
- `ent_id_valid`, `ext_id_valid`  in  1 each: single-cycle ID-reader strobe, synchronous to `clk`.
- `ent_id_uni`, `ext_id_uni`  in  1 each: class of the read ID, valid while the matching `*_id_valid` is 1.
- `is_vacated_space`, `uni_is_vacated_space`  in  1 each: space availability from the occupancy counter.
- `ent_barrier_up`, `ext_barrier_up`  out  1 each: barrier raise commands.
- `ent_denied`  out  1: one-cycle pulse when entry is refused for lack of space.
- `car_entered`, `is_uni_car_entered`  out  1 each: entry event pulse and its class.
- `car_exited`, `is_uni_car_exited`  out  1 each: exit event pulse and its class.

## Operation
- Each lane has a 2-flop synchronizer on `arrive` and on `pass`, followed by a debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal synchronized samples.
- Per-lane FSM with states IDLE, WAIT_ID, OPEN, PASSING, HOLD. A shared timer clears on every state change.
- IDLE: debounced `arrive` = 1 -> WAIT_ID.
- WAIT_ID, on `id_valid`: latch `id_uni` as the class.
  - Exit lane: -> OPEN.
  - Entry lane: if the class-matching space input is 1 -> OPEN. Otherwise pulse `ent_denied` for one cycle and -> HOLD. A uni car checks `uni_is_vacated_space`; a normal car checks `is_vacated_space`.
- WAIT_ID, timer reaching `ID_TIMEOUT` -> HOLD.
- OPEN: barrier up.
  - Debounced `pass` = 1 -> PASSING.
  - Timer reaching `PASS_TIMEOUT` -> HOLD with no event (car backed out).
- PASSING: barrier up. When debounced `pass` = 0 and debounced `arrive` = 0, emit the lane event and -> IDLE.
- HOLD: barrier down; -> IDLE once debounced `arrive` = 0.
- `id_valid` outside WAIT_ID is ignored. Space inputs are sampled only in the `id_valid` acceptance cycle.
- Simultaneous events: if both lanes complete in the same cycle, `car_entered` fires that cycle and `car_exited` fires one cycle later from a pending register. The next exit event cannot occur before the pending register drains, so no event is ever lost.

## Timing
- Reset values: every output 0, both FSMs in IDLE, debounce counters and timers 0, pending register clear.
- Raw `arrive` rise to WAIT_ID entry: 2 + `DEBOUNCE_CYCLES` cycles.
- `id_valid` accepted in cycle N: `barrier_up` = 1 from cycle N+1. `ent_denied` = 1 in cycle N+1 only.
- Event pulses are registered and last exactly one cycle. They rise in the cycle after the PASSING exit condition is seen.
- `is_uni_car_*` is valid in the pulse cycle and holds its value until the next event of that lane.
- Timers saturate at their limit, never wrap. Timer width is clog2(max limit)+1.
- `start` deasserted mid-operation forces the reset values immediately. A partially passed car produces no event.

## Structure
- Shared package `parking_pkg`:
  - `lane_state_t` enum (IDLE, WAIT_ID, OPEN, PASSING, HOLD).
  - Default timeout and debounce constants.
  - Event width constants shared with the occupancy counter.
- Sub-module `parking_lane_fsm`: synchronizers, debouncers, timer and FSM for one lane, with an `IS_ENTRY` parameter enabling the space check and `denied`. It is instantiated twice.
- The top level holds the exit pending register and the output registers.

## Test plan
- Entry, normal car, `is_vacated_space` = 1: `arrive` high 10 cycles, `id_valid` with `id_uni` = 0, `pass` 1 then 0, `arrive` 0 -> one `car_entered` pulse with `is_uni_car_entered` = 0; barrier up from the cycle after `id_valid` until the pulse.
- Entry, uni car, `uni_is_vacated_space` = 0: `id_valid` with `id_uni` = 1 -> `ent_denied` pulse 1 cycle, barrier never raised, no `car_entered`, lane returns to IDLE after `arrive` drops.
- Bounce: `ent_arrive` toggling every 2 cycles with `DEBOUNCE_CYCLES` = 4 -> FSM stays IDLE. A stable high of 6 cycles -> WAIT_ID.
- Timeouts: no `id_valid` for 64 cycles -> HOLD, no event. After a grant, no `pass` for 256 cycles -> barrier down, no event.
- Simultaneous completion of entry (normal) and exit (uni) in the same cycle -> `car_entered` in cycle N, `car_exited` with `is_uni_car_exited` = 1 in cycle N+1.
- `start` driven 0 while in PASSING -> all outputs 0 at once. After `start` = 1 the FSM is in IDLE and no event is emitted.
